// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared constants and the round-robin search helper for the FIFO write arbiter.
package fifo_arb_pkg;

    localparam int ARB_WIDTH    = 8;
    localparam int ARB_NREQ     = 4;
    localparam int ARB_IDW      = 2;
    localparam int ARB_BURST    = 4;
    localparam int ARB_MAX_NREQ = 8;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    // First set bit of req searching ptr, ptr+1, ... modulo nreq.
    // The loop runs from the farthest distance down so the nearest hit wins last.
    function automatic pick_t rr_pick(input logic [ARB_MAX_NREQ-1:0] req,
                                      input logic [2:0]              ptr,
                                      input int                      nreq);
        pick_t r;
        int    ii;
        r = '0;
        for (int k = ARB_MAX_NREQ - 1; k >= 0; k--) begin
            if (k < nreq) begin
                ii = (int'(ptr) + k) % nreq;
                if (req[ii[2:0]]) begin
                    r.found = 1'b1;
                    r.idx   = ii[2:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester and FIFO write-port bundle shared between producers and the arbiter.
interface fifo_wr_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int WIDTH = ARB_WIDTH,
    parameter int NREQ  = ARB_NREQ,
    parameter int IDW   = ARB_IDW
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] data_in;
    logic [NREQ-1:0]       gnt;
    logic                  fifo_full;
    logic                  fifo_wen;
    logic [WIDTH-1:0]      fifo_din;
    logic [IDW-1:0]        fifo_tag;

    // Producers plus FIFO model side.
    modport master (
        output req, data_in, fifo_full,
        input  gnt, fifo_wen, fifo_din, fifo_tag
    );

    // Arbiter side.
    modport slave (
        input  req, data_in, fifo_full,
        output gnt, fifo_wen, fifo_din, fifo_tag
    );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational priority rotator: first requester at or after ptr, wrapping.
module rr_pick_logic
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = ARB_NREQ,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [PW-1:0]   idx,
    output logic            found
);
    pick_t pk;

    assign pk    = rr_pick(ARB_MAX_NREQ'(req), 3'(ptr), NREQ);
    assign idx   = PW'(pk.idx);
    assign found = pk.found;
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter with burst lock in front of a synchronous FIFO.
// Grant is combinational; data is written at the edge ending the grant cycle.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int WIDTH = ARB_WIDTH,
    parameter int NREQ  = ARB_NREQ,
    parameter int IDW   = ARB_IDW,
    parameter int BURST = ARB_BURST
) (
    input  logic               clk,
    input  logic               reset,
    fifo_wr_arbiter_if.slave   bus,
    output logic               busy,
    output logic [15:0]        grant_cnt
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW = $clog2(BURST + 1);

    logic [PW-1:0]   ptr, owner, ptr_nxt;
    logic            owner_vld;
    logic [BW-1:0]   burst_cnt;

    logic [PW-1:0]   pick_idx, g_idx;
    logic            pick_found, any_gnt;
    logic [NREQ-1:0] owner_oh;
    logic            owner_req, others_req, keep_owner;

    rr_pick_logic #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req   (bus.req),
        .ptr   (ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign owner_oh   = NREQ'(1) << owner;
    assign owner_req  = |(bus.req & owner_oh);
    assign others_req = |(bus.req & ~owner_oh);
    // Owner keeps the port until its burst budget is spent, unless nobody else wants it.
    assign keep_owner = owner_vld && owner_req && ((burst_cnt < BW'(BURST)) || !others_req);
    assign ptr_nxt    = (g_idx == PW'(NREQ - 1)) ? '0 : g_idx + 1'b1;

    // Grant decision: reset and FIFO full block everything, owner first, then rotation.
    always_comb begin
        any_gnt = 1'b0;
        g_idx   = '0;
        if (!reset && !bus.fifo_full) begin
            if (keep_owner) begin
                any_gnt = 1'b1;
                g_idx   = owner;
            end else if (pick_found) begin
                any_gnt = 1'b1;
                g_idx   = pick_idx;
            end
        end
    end

    // Steer the granted requester's data and tag onto the FIFO write port.
    always_comb begin
        bus.gnt      = '0;
        bus.fifo_wen = any_gnt;
        bus.fifo_din = '0;
        bus.fifo_tag = '0;
        if (any_gnt) begin
            bus.gnt      = NREQ'(1) << g_idx;
            bus.fifo_tag = IDW'(g_idx);
        end
        for (int i = 0; i < NREQ; i++) begin
            if (bus.gnt[i]) bus.fifo_din = bus.fifo_din | bus.data_in[i*WIDTH +: WIDTH];
        end
    end

    // Owner/burst/pointer bookkeeping; a full FIFO freezes all of it.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr       <= '0;
            owner     <= '0;
            owner_vld <= 1'b0;
            burst_cnt <= '0;
            busy      <= 1'b0;
            grant_cnt <= '0;
        end else if (!bus.fifo_full) begin
            if (any_gnt) begin
                if (owner_vld && (g_idx == owner)) begin
                    if (burst_cnt != BW'(BURST)) burst_cnt <= burst_cnt + 1'b1;
                end else begin
                    owner     <= g_idx;
                    owner_vld <= 1'b1;
                    burst_cnt <= BW'(1);
                end
                ptr       <= ptr_nxt;
                busy      <= 1'b1;
                grant_cnt <= grant_cnt + 16'd1;
            end else begin
                owner_vld <= 1'b0;
                burst_cnt <= '0;
                busy      <= 1'b0;
            end
        end
    end
endmodule
